// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU front end:
// default widths, instruction field positions and the fetch state encoding.
package cpu_pkg;

    localparam int PC_W_DEF = 8;
    localparam int IW_DEF   = 16;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    localparam logic [7:0] NOP_OPCODE = 8'h00;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: LoadPC beats IncPC, increment wraps modulo 2^PC_W.
// The IR immediate is zero-extended (or truncated) to the PC width.
module pc_reg #(
    parameter int                PC_W     = 8,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc_pc,
    input  logic            load_pc,
    input  logic            sel_pc,
    input  logic [PC_W-1:0] reg_data,
    input  logic [7:0]      imm,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] imm_ext;
    logic [PC_W-1:0] pc_reg_q;
    logic [PC_W-1:0] pc_next;

    genvar gi;
    generate
        for (gi = 0; gi < PC_W; gi++) begin : g_imm_ext
            if (gi < 8) begin : g_bit
                assign imm_ext[gi] = imm[gi];
            end else begin : g_zero
                assign imm_ext[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        pc_next = pc_reg_q;
        if (load_pc) begin
            pc_next = sel_pc ? imm_ext : reg_data;
        end else if (inc_pc) begin
            pc_next = pc_reg_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg_q <= RESET_PC;
        end else begin
            pc_reg_q <= pc_next;
        end
    end

    assign pc = pc_reg_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// CPU front end: PC plus instruction register, fetching words over a
// req/ready handshake. The request address is frozen for the whole wait.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              IW       = IW_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            LoadIR,
    input  logic            IncPC,
    input  logic            LoadPC,
    input  logic            SelPC,
    input  logic [PC_W-1:0] reg_data,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic [IW-1:0]   mem_rdata,
    input  logic            mem_ready,
    output logic [7:0]      Opcode,
    output logic [7:0]      Imm,
    output logic [PC_W-1:0] pc,
    output logic            ir_valid,
    output logic            fetch_busy
);

    fetch_state_t    state_reg;
    logic [IW-1:0]   ir_reg;

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .inc_pc   (IncPC),
        .load_pc  (LoadPC),
        .sel_pc   (SelPC),
        .reg_data (reg_data),
        .imm      (Imm),
        .pc       (pc)
    );

    // mem_ready is only honoured in WAIT, so a stray ready after reset is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            ir_reg     <= '0;
            ir_valid   <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            fetch_busy <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (LoadIR) begin
                        mem_addr   <= pc;
                        mem_req    <= 1'b1;
                        fetch_busy <= 1'b1;
                        ir_valid   <= 1'b0;
                        state_reg  <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        ir_reg     <= mem_rdata;
                        ir_valid   <= 1'b1;
                        mem_req    <= 1'b0;
                        fetch_busy <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign Opcode = ir_reg[OPC_HI:OPC_LO];
    assign Imm    = ir_reg[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        LoadIR, IncPC, LoadPC, SelPC;
    logic [7:0]  reg_data;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [7:0]  Opcode, Imm, pc;
    logic        ir_valid, fetch_busy;

    logic [15:0] mem_arr [256];

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0]  pc_m;
    logic [15:0] ir_m;
    logic [7:0]  addr_m;
    logic        valid_m;
    logic        busy_m;

    instr_fetch_unit #(.PC_W(8), .IW(16), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .reset      (reset),
        .LoadIR     (LoadIR),
        .IncPC      (IncPC),
        .LoadPC     (LoadPC),
        .SelPC      (SelPC),
        .reg_data   (reg_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .Opcode     (Opcode),
        .Imm        (Imm),
        .pc         (pc),
        .ir_valid   (ir_valid),
        .fetch_busy (fetch_busy)
    );

    assign mem_rdata = mem_arr[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of controller inputs, then advance the model by the
    // rules: PC update first-class, fetch captures the pre-edge pc.
    task automatic step(input logic li, input logic ip, input logic lp,
                        input logic sp, input logic [7:0] rd, input logic rdy);
        logic [7:0] pc_old;
        LoadIR = li; IncPC = ip; LoadPC = lp; SelPC = sp;
        reg_data = rd; mem_ready = rdy;
        @(posedge clk);
        pc_old = pc_m;
        if (lp)      pc_m = sp ? ir_m[7:0] : rd;
        else if (ip) pc_m = pc_m + 8'd1;
        if (!busy_m && li) begin
            addr_m  = pc_old;
            busy_m  = 1'b1;
            valid_m = 1'b0;
        end else if (busy_m && rdy) begin
            ir_m    = mem_arr[addr_m];
            valid_m = 1'b1;
            busy_m  = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy);
        LoadIR = 0; IncPC = 0; LoadPC = 0; SelPC = 0; reg_data = 0; mem_ready = rdy;
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        pc_m = 8'h00; ir_m = 16'h0000; addr_m = 8'h00; valid_m = 0; busy_m = 0;
    endtask

    task automatic set_pc(input logic [7:0] v);
        step(0, 0, 1, 0, v, 0);
    endtask

    task automatic test_reset;
        do_reset(0);
        checks++;
        if ({pc, mem_req, mem_addr, ir_valid, fetch_busy, Opcode, Imm} !== {8'h00, 1'b0, 8'h00, 1'b0, 1'b0, NOP_OPCODE, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: got pc=%h req=%b addr=%h v=%b busy=%b op=%h imm=%h, want all zero",
                     pc, mem_req, mem_addr, ir_valid, fetch_busy, Opcode, Imm);
        end
        // reset in the middle of a stalled fetch
        set_pc(8'h07);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_prefetch_req: got %b want 1", mem_req);
        end
        do_reset(0);
        checks++;
        if ({mem_req, fetch_busy, pc, Opcode, ir_valid} !== {1'b0, 1'b0, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_midfetch: got req=%b busy=%b pc=%h op=%h v=%b want 0s",
                     mem_req, fetch_busy, pc, Opcode, ir_valid);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
        checks++;
        if ({ir_valid, Opcode, Imm, mem_req} !== {1'b0, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_late_ready: got v=%b op=%h imm=%h req=%b want IR untouched",
                     ir_valid, Opcode, Imm, mem_req);
        end
        $display("test_reset done");
    endtask

    task automatic test_zero_wait;
        mem_arr[8'h05] = 16'h4203;
        set_pc(8'h05);
        step(1, 0, 0, 0, 0, 1);
        checks++;
        if ({mem_req, mem_addr, fetch_busy, ir_valid} !== {1'b1, 8'h05, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL zw_request: got req=%b addr=%h busy=%b v=%b want 1 05 1 0",
                     mem_req, mem_addr, fetch_busy, ir_valid);
        end
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if ({Opcode, Imm, ir_valid, mem_req, fetch_busy} !== {8'h42, 8'h03, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL zw_capture: got op=%h imm=%h v=%b req=%b busy=%b want 42 03 1 0 0",
                     Opcode, Imm, ir_valid, mem_req, fetch_busy);
        end
        $display("fetch addr=05 word=%h", {Opcode, Imm});
    endtask

    task automatic test_wait_states;
        logic [15:0] word;
        word = 16'($urandom);
        mem_arr[8'h33] = word;
        set_pc(8'h33);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step((i == 1), (i == 2), 0, 0, 0, 0);
            checks++;
            if ({mem_req, mem_addr, fetch_busy} !== {1'b1, 8'h33, 1'b1}) begin
                errors++;
                $display("FAIL wait_stable[%0d]: got req=%b addr=%h busy=%b want 1 33 1",
                         i, mem_req, mem_addr, fetch_busy);
            end
        end
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if ({Opcode, Imm, ir_valid, fetch_busy, mem_req} !== {word, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL wait_capture: got ir=%h v=%b busy=%b req=%b want %h 1 0 0",
                     {Opcode, Imm}, ir_valid, fetch_busy, mem_req, word);
        end
        mem_arr[8'h33] = ~word;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if ({Opcode, Imm, ir_valid, mem_req} !== {word, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wait_single_capture: got ir=%h v=%b req=%b want %h 1 0",
                     {Opcode, Imm}, ir_valid, mem_req, word);
        end
        $display("fetch addr=33 word=%h (after 4 wait cycles)", word);
    endtask

    task automatic test_pc_priority;
        set_pc(8'h10);
        step(0, 1, 1, 0, 8'h80, 0);
        checks++;
        if (pc !== 8'h80) begin
            errors++;
            $display("FAIL pc_loadpc_over_inc: got %h want 80", pc);
        end
        mem_arr[8'h80] = 16'h113C;
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 1, 8'h99, 0);
        checks++;
        if ({pc, Imm} !== {8'h3C, 8'h3C}) begin
            errors++;
            $display("FAIL pc_load_imm: got pc=%h imm=%h want 3c 3c", pc, Imm);
        end
        $display("pc priority: reg_data load then imm load -> %h", pc);
    endtask

    task automatic test_wrap;
        set_pc(8'hFF);
        step(0, 1, 0, 0, 0, 0);
        checks++;
        if (pc !== 8'h00) begin
            errors++;
            $display("FAIL pc_wrap: got %h want 00", pc);
        end
        $display("pc wrap ff -> %h", pc);
    endtask

    task automatic test_same_edge;
        logic [15:0] word;
        word = 16'($urandom);
        mem_arr[8'h20] = word;
        mem_arr[8'h21] = ~word;
        set_pc(8'h20);
        step(1, 1, 0, 0, 0, 0);
        checks++;
        if ({mem_addr, pc, mem_req} !== {8'h20, 8'h21, 1'b1}) begin
            errors++;
            $display("FAIL same_edge_addr: got addr=%h pc=%h req=%b want 20 21 1", mem_addr, pc, mem_req);
        end
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if ({Opcode, Imm} !== word) begin
            errors++;
            $display("FAIL same_edge_word: got %h want %h", {Opcode, Imm}, word);
        end
        $display("fetch addr=20 word=%h (with same-edge IncPC)", word);
    endtask

    task automatic test_random;
        logic li, ip, lp, sp, rdy;
        logic [7:0] rd;
        int fetches;
        fetches = 0;
        do_reset(0);
        for (int i = 0; i < 256; i++) mem_arr[i] = 16'($urandom);
        for (int n = 0; n < 400; n++) begin
            li  = ($urandom_range(0, 2) == 0);
            ip  = ($urandom_range(0, 2) == 0);
            lp  = ($urandom_range(0, 4) == 0);
            sp  = 1'($urandom);
            rd  = 8'($urandom);
            rdy = ($urandom_range(0, 2) != 0);
            step(li, ip, lp, sp, rd, rdy);
            checks++;
            if ({pc, mem_req, mem_addr, ir_valid, fetch_busy, Opcode, Imm} !==
                {pc_m, busy_m, addr_m, valid_m, busy_m, ir_m}) begin
                errors++;
                $display("FAIL random[%0d]: got pc=%h req=%b addr=%h v=%b busy=%b ir=%h want pc=%h req=%b addr=%h v=%b busy=%b ir=%h",
                         n, pc, mem_req, mem_addr, ir_valid, fetch_busy, {Opcode, Imm},
                         pc_m, busy_m, addr_m, valid_m, busy_m, ir_m);
            end
            if (busy_m == 1'b0 && valid_m && rdy && fetches < 1000) fetches++;
        end
        $display("random run: 400 cycles, final pc=%h ir=%h", pc_m, ir_m);
    endtask

    initial begin
        reset = 1'b0;
        LoadIR = 0; IncPC = 0; LoadPC = 0; SelPC = 0; reg_data = 0; mem_ready = 0;
        for (int i = 0; i < 256; i++) mem_arr[i] = 16'($urandom);
        test_reset;
        test_zero_wait;
        test_wait_states;
        test_pc_priority;
        test_wrap;
        test_same_edge;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
